// File: rtl/key_cond_defs.sv
// Shared definitions for the pushbutton conditioner: per-key FSM state encoding
// and the shortened timing constants used in simulation.
package key_cond_defs;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_t;

    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_REPEAT_DELAY    = 10;
    localparam int unsigned SIM_REPEAT_RATE     = 3;

endpackage

// File: rtl/key_debounce_1.sv
// Conditioning for a single active-low pushbutton: 2-flop synchronizer,
// debounce FSM, and registered level / press / release / auto-repeat outputs.
module key_debounce_1
    import key_cond_defs::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 5_000_000,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam logic [CNT_WIDTH-1:0] D_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RR_LAST =
        (REPEAT_RATE == 0) ? '0 : CNT_WIDTH'(REPEAT_RATE - 1);

    logic                 sync1, sync2, p;
    key_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d, rcnt_q, rcnt_d;
    logic                 armed_q, armed_d;
    logic                 level_d, press_d, release_d, repeat_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign p = ~sync2;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= RELEASED;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            armed_q     <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
            armed_q     <= armed_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_repeat  <= repeat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        rcnt_d    = rcnt_q;
        armed_d   = armed_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            RELEASED: begin
                if (p) begin
                    state_d = PRESS_PEND;
                    dcnt_d  = '0;
                end
            end
            PRESS_PEND: begin
                if (!p) begin
                    state_d = RELEASED;
                end else if (dcnt_q == D_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    armed_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CNT_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_d = RELEASE_PEND;
                    dcnt_d  = '0;
                end else if (REPEAT_RATE != 0) begin
                    // rcnt restarts at every strobe; armed selects delay vs rate period
                    if (rcnt_q == (armed_q ? RR_LAST : RD_LAST)) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                        armed_d  = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            RELEASE_PEND: begin
                if (p) begin
                    state_d = PRESSED;
                end else if (dcnt_q == D_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    rcnt_d    = '0;
                    armed_d   = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: one independent debounce/repeat channel per KEY bit,
// all outputs registered for use as strobes and resets downstream.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 5_000_000,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_1 #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_key (
            .CLOCK_50   (CLOCK_50),
            .reset      (reset),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_repeat (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity, checked
// against a run-length behavioural model; a second instance has repeat disabled.
module tb_key_conditioner;
    import key_cond_defs::*;

    localparam int D  = SIM_DEBOUNCE_CYCLES;
    localparam int RD = SIM_REPEAT_DELAY;
    localparam int RR = SIM_REPEAT_RATE;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [1:0] key_n    = 2'b11;
    logic [1:0] key_level, key_press, key_release, key_repeat;
    logic [1:0] nr_level, nr_press, nr_release, nr_repeat;

    always #5 CLOCK_50 = ~CLOCK_50;

    key_conditioner #(
        .NUM_KEYS(2), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_WIDTH(32)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_repeat(key_repeat)
    );

    key_conditioner #(
        .NUM_KEYS(2), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(0), .CNT_WIDTH(32)
    ) dut_nr (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n),
        .key_level(nr_level), .key_press(nr_press),
        .key_release(nr_release), .key_repeat(nr_repeat)
    );

    // Reference model: a change is accepted after D+1 consecutive synchronized
    // samples disagreeing with the current level; held samples drive repeats.
    logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11;
    logic [1:0] m_lvl = '0;
    int         m_run[2];
    int         m_held[2][2];
    logic [1:0] e_press = '0, e_release = '0, e_rep = '0, e_rep_nr = '0;
    logic       mp;

    function automatic bit repeat_due(int held, int rate);
        return rate != 0 && held >= RD && ((held - RD) % rate) == 0;
    endfunction

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_lvl = '0;
            e_press = '0; e_release = '0; e_rep = '0; e_rep_nr = '0;
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 0; m_held[0][k] = 0; m_held[1][k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mp = ~m_s2[k];
                e_press[k] = 1'b0; e_release[k] = 1'b0; e_rep[k] = 1'b0; e_rep_nr[k] = 1'b0;
                if (mp != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        m_lvl[k] = mp;
                        m_run[k] = 0;
                        m_held[0][k] = 0; m_held[1][k] = 0;
                        if (mp) e_press[k] = 1'b1;
                        else    e_release[k] = 1'b1;
                    end
                end else if (m_run[k] != 0) begin
                    m_run[k] = 0;
                end else if (m_lvl[k]) begin
                    m_held[0][k]++; m_held[1][k]++;
                    e_rep[k]    = repeat_due(m_held[0][k], RR);
                    e_rep_nr[k] = repeat_due(m_held[1][k], 0);
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
        end
    end

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    int n_press[2], n_rel[2], n_rep[2], last_press[2], last_rel[2], last_rep[2];
    int n_rep_nr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge CLOCK_50);
        cyc++;
        check("level",    {30'd0, key_level},   {30'd0, m_lvl});
        check("press",    {30'd0, key_press},   {30'd0, e_press});
        check("release",  {30'd0, key_release}, {30'd0, e_release});
        check("repeat",   {30'd0, key_repeat},  {30'd0, e_rep});
        check("nr_level", {30'd0, nr_level},    {30'd0, m_lvl});
        check("nr_press", {30'd0, nr_press},    {30'd0, e_press});
        check("nr_rel",   {30'd0, nr_release},  {30'd0, e_release});
        check("nr_rep",   {30'd0, nr_repeat},   {30'd0, e_rep_nr});
        check("excl", {30'd0, (key_press & key_repeat) | (key_press & key_release)
                              | (key_repeat & key_release)}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            if (key_press[k])   begin n_press[k]++; last_press[k] = cyc; end
            if (key_release[k]) begin n_rel[k]++;   last_rel[k]   = cyc; end
            if (key_repeat[k])  begin n_rep[k]++;   last_rep[k]   = cyc; end
            if (nr_repeat[k])   n_rep_nr++;
        end
    endtask

    task automatic hold(input logic [1:0] v, input int n);
        key_n = v;
        repeat (n) step();
    endtask

    int t0, sp0, sp1, sr0, sr1, sq0, sq1;

    task automatic snap();
        sp0 = n_press[0]; sp1 = n_press[1];
        sr0 = n_rel[0];   sr1 = n_rel[1];
        sq0 = n_rep[0];   sq1 = n_rep[1];
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            n_press[k] = 0; n_rel[k] = 0; n_rep[k] = 0;
            last_press[k] = 0; last_rel[k] = 0; last_rep[k] = 0;
        end
        // 1: reset state
        #1 reset = 1'b1;
        hold(2'b11, 3);
        check("rst_out", {24'd0, key_level, key_press, key_release, key_repeat}, 32'd0);
        reset = 1'b0;
        hold(2'b11, 20);
        check("idle_out", {24'd0, key_level, key_press, key_release, key_repeat}, 32'd0);

        // 2: long press with repeats
        snap(); t0 = cyc;
        hold(2'b10, 30);
        hold(2'b11, 20);
        check("t2_press_edge", last_press[0] - t0 - 1, 6);
        check("t2_rep_count",  n_rep[0] - sq0, 6);
        check("t2_rep_last",   last_rep[0] - t0 - 1, 31);
        check("t2_rel_edge",   last_rel[0] - t0 - 1, 36);
        check("t2_rel_count",  n_rel[0] - sr0, 1);

        // 3: short glitch then real press
        snap();
        hold(2'b10, 3);
        hold(2'b11, 1);
        t0 = cyc;
        hold(2'b10, 20);
        check("t3_press_count", n_press[0] - sp0, 1);
        check("t3_press_edge",  last_press[0] - t0 - 1, 6);

        // 4: release with a bounce back low
        snap();
        hold(2'b11, 2);
        hold(2'b10, 2);
        t0 = cyc;
        hold(2'b11, 20);
        check("t4_rel_count",   n_rel[0] - sr0, 1);
        check("t4_rel_edge",    last_rel[0] - t0 - 1, 6);
        check("t4_press_count", n_press[0] - sp0, 0);

        // 5: both keys together
        snap(); t0 = cyc;
        hold(2'b00, 30);
        hold(2'b11, 20);
        check("t5_same_cycle", last_press[1] - last_press[0], 0);
        check("t5_press_edge", last_press[1] - t0 - 1, 6);
        check("t5_press_both", (n_press[0] - sp0) + (n_press[1] - sp1), 2);
        check("t5_rep_key1",   n_rep[1] - sq1, 6);

        // 6: reset while key 1 is mid-debounce
        snap();
        hold(2'b01, 5);
        reset = 1'b1;
        hold(2'b01, 3);
        check("t6_no_strobe", (n_press[1] - sp1) + (n_rel[1] - sr1) + (n_rep[1] - sq1), 0);
        t0 = cyc;
        reset = 1'b0;
        hold(2'b01, 20);
        check("t6_press_count", n_press[1] - sp1, 1);
        check("t6_press_edge",  last_press[1] - t0 - 1, 6);
        hold(2'b11, 20);

        // random activity, occasional reset pulses
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                hold(2'($urandom_range(0, 3)), 2);
                reset = 1'b0;
            end
            hold(2'($urandom_range(0, 3)), $urandom_range(1, 14));
        end
        hold(2'b11, 20);

        check("norepeat_total", n_rep_nr, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
